// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: prediction encoding and
// saturating counter helpers that work for any counter width up to 4 bits.
package bp_pkg;

   localparam int MAX_CTR_BITS = 4;

   localparam logic PRED_TAKEN     = 1'b1;
   localparam logic PRED_NOT_TAKEN = 1'b0;

   typedef logic [MAX_CTR_BITS-1:0] ctr_t;

   // Largest value a counter of the given width can hold
   function automatic ctr_t ctrMax(input int unsigned ctrBits);
      return ctr_t'((32'd1 << ctrBits) - 32'd1);
   endfunction

   // Increment that sticks at the top instead of wrapping to zero
   function automatic ctr_t satInc(input ctr_t value, input int unsigned ctrBits);
      return (value >= ctrMax(ctrBits)) ? value : ctr_t'(value + ctr_t'(1));
   endfunction

   // Decrement that sticks at zero instead of wrapping to the top
   function automatic ctr_t satDec(input ctr_t value);
      return (value == '0) ? value : ctr_t'(value - ctr_t'(1));
   endfunction

   // Weakly-not-taken is the value just below the taken threshold (MSB set)
   function automatic ctr_t weakNotTaken(input int unsigned ctrBits);
      if (ctrBits <= 1) begin
         return '0;
      end
      return ctr_t'((32'd1 << (ctrBits - 1)) - 32'd1);
   endfunction

endpackage

// File: rtl/bp_counter_table_if.sv
// Fetch/resolution facing bundle of the counter table. The master side is
// the pipeline (issues lookups and updates), the slave side is the table.
interface bp_counter_table_if #(
   parameter int PC_BITS    = 32,
   parameter int INDEX_BITS = 6,
   parameter int PERF_BITS  = 16
) ();

   logic                  lookup_valid;
   logic [PC_BITS-1:0]    lookup_pc;
   logic                  predict_valid;
   logic                  predict_taken;
   logic [INDEX_BITS-1:0] predict_index;
   logic                  update_valid;
   logic [INDEX_BITS-1:0] update_index;
   logic                  update_taken;
   logic                  update_mispredict;
   logic [PERF_BITS-1:0]  perf_lookups;
   logic [PERF_BITS-1:0]  perf_mispredicts;

   modport master (
      output lookup_valid, lookup_pc,
      output update_valid, update_index, update_taken, update_mispredict,
      input  predict_valid, predict_taken, predict_index,
      input  perf_lookups, perf_mispredicts
   );

   modport slave (
      input  lookup_valid, lookup_pc,
      input  update_valid, update_index, update_taken, update_mispredict,
      output predict_valid, predict_taken, predict_index,
      output perf_lookups, perf_mispredicts
   );

endinterface

// File: rtl/bp_sat_counter.sv
// One table entry: a saturating counter whose prediction output reflects the
// value after this cycle's update, so a same-cycle lookup sees the new state.
module bp_sat_counter
   import bp_pkg::*;
#(
   parameter int CTR_BITS = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic updEn_i,
   input  logic taken_i,
   output logic predNext_o
);

   logic [CTR_BITS-1:0] ctr_q;
   logic [CTR_BITS-1:0] ctr_d;
   ctr_t                ctrWide;

   // Next counter value: move toward the resolved direction, never wrapping
   always_comb begin
      ctrWide = ctr_t'(ctr_q);
      ctr_d   = ctr_q;
      if (updEn_i) begin
         if (taken_i) begin
            ctr_d = CTR_BITS'(satInc(ctrWide, CTR_BITS));
         end else begin
            ctr_d = CTR_BITS'(satDec(ctrWide));
         end
      end
   end

   // Counter storage, starting weakly-not-taken
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctr_q <= CTR_BITS'(weakNotTaken(CTR_BITS));
      end else begin
         ctr_q <= ctr_d;
      end
   end

   assign predNext_o = ctr_d[CTR_BITS-1] ? PRED_TAKEN : PRED_NOT_TAKEN;

endmodule

// File: rtl/bp_counter_table.sv
// Table of saturating counters indexed by PC, optionally hashed with global
// history (gshare). Registered prediction, write-first bypass, perf counters.
module bp_counter_table
   import bp_pkg::*;
#(
   parameter int PC_BITS    = 32,
   parameter int INDEX_BITS = 6,
   parameter int CTR_BITS   = 2,
   parameter int GHR_BITS   = 0,
   parameter int PERF_BITS  = 16
) (
   input logic              clk,
   input logic              rst_n,
   bp_counter_table_if.slave bus
);

   localparam int DEPTH = 1 << INDEX_BITS;

   logic [INDEX_BITS-1:0] ghrTerm;
   logic [INDEX_BITS-1:0] lookupIdx;
   logic [DEPTH-1:0]      entryPredNext;

   logic                  predValid_q, predValid_d;
   logic                  predTaken_q, predTaken_d;
   logic [INDEX_BITS-1:0] predIndex_q, predIndex_d;
   logic [PERF_BITS-1:0]  perfLookups_q, perfLookups_d;
   logic [PERF_BITS-1:0]  perfMispredicts_q, perfMispredicts_d;

   logic                  unusedPcBits;

   // Word-aligned PCs: the low two bits and the bits above the index never matter
   assign unusedPcBits = ^{bus.lookup_pc[PC_BITS-1:INDEX_BITS+2], bus.lookup_pc[1:0]};

   generate
      if (GHR_BITS > 0) begin : genGhr
         logic [GHR_BITS-1:0] ghr_q;
         logic [GHR_BITS-1:0] ghr_d;

         // History shifts in resolved outcomes only, never speculative ones
         always_comb begin
            ghr_d = ghr_q;
            if (bus.update_valid) begin
               ghr_d = GHR_BITS'({ghr_q, bus.update_taken});
            end
         end

         // History register; lookups this cycle hash with the old value
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               ghr_q <= '0;
            end else begin
               ghr_q <= ghr_d;
            end
         end

         assign ghrTerm = INDEX_BITS'(ghr_q);
      end else begin : genNoGhr
         assign ghrTerm = '0;
      end
   endgenerate

   assign lookupIdx = bus.lookup_pc[INDEX_BITS+1:2] ^ ghrTerm;

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : genEntry
         logic updHit;

         assign updHit = bus.update_valid && (bus.update_index == INDEX_BITS'(i));

         bp_sat_counter #(
            .CTR_BITS (CTR_BITS)
         ) uCtr (
            .clk        (clk),
            .rst_n      (rst_n),
            .updEn_i    (updHit),
            .taken_i    (bus.update_taken),
            .predNext_o (entryPredNext[i])
         );
      end
   endgenerate

   // Prediction and statistics next-state; the entry read is its post-update value
   always_comb begin
      predValid_d       = bus.lookup_valid;
      predTaken_d       = predTaken_q;
      predIndex_d       = predIndex_q;
      perfLookups_d     = perfLookups_q;
      perfMispredicts_d = perfMispredicts_q;
      if (bus.lookup_valid) begin
         predTaken_d = entryPredNext[lookupIdx];
         predIndex_d = lookupIdx;
         if (perfLookups_q != '1) begin
            perfLookups_d = perfLookups_q + PERF_BITS'(1);
         end
      end
      if (bus.update_valid && bus.update_mispredict && (perfMispredicts_q != '1)) begin
         perfMispredicts_d = perfMispredicts_q + PERF_BITS'(1);
      end
   end

   // Output and statistics registers; reset drops whatever arrives that cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         predValid_q       <= 1'b0;
         predTaken_q       <= PRED_NOT_TAKEN;
         predIndex_q       <= '0;
         perfLookups_q     <= '0;
         perfMispredicts_q <= '0;
      end else begin
         predValid_q       <= predValid_d;
         predTaken_q       <= predTaken_d;
         predIndex_q       <= predIndex_d;
         perfLookups_q     <= perfLookups_d;
         perfMispredicts_q <= perfMispredicts_d;
      end
   end

   assign bus.predict_valid    = predValid_q;
   assign bus.predict_taken    = predTaken_q;
   assign bus.predict_index    = predIndex_q;
   assign bus.perf_lookups     = perfLookups_q;
   assign bus.perf_mispredicts = perfMispredicts_q;

endmodule
